cnn_frame_loader: RTL and testbench
===================================

Name: cnn_frame_loader

Overview:
- Upstream feeder for the CNN compute core.
- Accepts the input feature map as a byte stream over a valid/ready handshake and assembles it into the flat ROWS*COLS*DW-bit `mem` vector the core consumes.
- Asserts `en` for the duration of one inference and holds `mem` stable until the core signals completion.
- Rejects malformed frames using an end-of-frame marker.

Parameters:
- ROWS, 30, feature-map rows
- COLS, 10, feature-map columns
- DW, 8, bits per element (signed 8-bit activations)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_b  in  1  reset; asynchronous, active-high. The name is kept for consistency with the rest of the design.
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader can accept a byte
- s_data  in  DW  stream byte, row-major order (row 0 col 0 first)
- s_last  in  1  marks final byte of frame; qualified by s_valid&s_ready
- cnn_done  in  1  single-cycle pulse from core: frame inference complete
- en  out  1  enable to core; high for the whole inference
- mem  out  ROWS*COLS*DW, big-endian [0:N*DW-1]  assembled frame
- busy  out  1  high while en is high
- frame_err  out  1  one-cycle pulse on a malformed frame
- frame_cnt  out  16  completed inferences, wraps at 0xFFFF->0

Behaviour:
- N = ROWS*COLS = 300. Element k = r*COLS+c occupies mem[k*DW +: DW].
- Reset (async, rst_b=1) forces:
  - state LOAD, idx=0
  - s_ready=0, en=0, busy=0, frame_err=0, frame_cnt=0
  - mem = all zero
- States: LOAD, RUN. All outputs are registered.
- LOAD:
  - s_ready=1 from the first edge after reset deassertion, and again from the first edge after re-entering LOAD.
  - A byte is accepted when s_valid&s_ready at an edge. On that edge mem[idx*DW +: DW] <= s_data and idx <= idx+1.
  - Accepted byte with idx<N-1 and s_last=1: short frame.
    - frame_err pulses the next cycle; idx <= 0; stay LOAD.
    - The partial mem contents are left as-is; they are overwritten by the next frame.
  - Accepted byte with idx==N-1 and s_last=0: long/unaligned frame.
    - The byte is written, frame_err pulses, idx <= 0, stay LOAD.
    - Subsequent bytes are treated as the start of a new frame.
  - Accepted byte with idx==N-1 and s_last=1: good frame.
    - On that edge: state <= RUN, s_ready <= 0, en <= 1, busy <= 1, idx <= 0.
    - Latency from last-byte acceptance edge to en high: 1 cycle (visible after that edge).
  - cnn_done in LOAD is ignored.
- RUN:
  - s_ready=0; mem is frozen (no writes); s_valid is ignored.
  - cnn_done is honoured only while en==1. On the cnn_done edge: en <= 0, busy <= 0, frame_cnt <= frame_cnt+1, state <= LOAD, s_ready <= 1.
  - The next frame may begin accepting on the following edge, so the minimum gap between en falling and the next byte accept is 1 cycle.
  - No timeout: RUN persists until cnn_done.
- frame_err and successful completion never coincide; frame_err is only generated in LOAD.
- Reset asserted mid-LOAD or mid-RUN aborts immediately: en drops asynchronously, mem clears, idx and frame_cnt return to 0.
- frame_cnt wraps silently.

Decomposition:
- Shared package cnn_pkg:
  - constants ROWS=30, COLS=10, DW=8, N=ROWS*COLS, IDX_W=$clog2(N)=9
  - loader state enum {LOAD, RUN}
  - the same constants are reused by the core's mem port width
- One natural sub-module: cnn_frame_bank.
  - N x DW register array with write-enable, index and data inputs, flattened `mem` output, and async clear.
  - Keeps the FSM/handshake logic separate from the 2400-bit storage.

Test Plan:
- Reset then stream bytes k mod 256 for k=0..299, s_valid continuously high, s_last on k=299 -> s_ready=1 one cycle after reset release; en=1 exactly one cycle after byte 299 is accepted; mem[8k +: 8]==k mod 256 for all k; s_ready=0 while en=1.
- In RUN, drive s_valid=1 with s_data=0xFF for 20 cycles, then pulse cnn_done -> mem unchanged; en falls on the cnn_done edge; frame_cnt=1; s_ready=1 on the next cycle.
- Send 150 bytes with s_last on byte 149, then a full good frame of 0x5A -> frame_err pulses exactly once, one cycle after byte 149; the second frame starts at idx 0; en rises after its byte 299; all mem bytes==0x5A.
- Send 300 bytes with no s_last, then 300 bytes with s_last on the final byte -> frame_err pulse after byte 299 of the first batch; en rises only after the second batch completes.
- Assert rst_b mid-LOAD (after 100 bytes), and separately mid-RUN -> en=0, s_ready=0, mem all zero, frame_cnt=0 during reset; the next full frame loads correctly from idx 0.
- Pulse cnn_done during LOAD, then toggle s_valid randomly (about 50% duty) across a full frame -> cnn_done ignored (frame_cnt unchanged); every byte is captured exactly once despite the gaps.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared feature-map geometry and loader state encoding
package cnn_pkg;

  localparam int ROWS  = 30;
  localparam int COLS  = 10;
  localparam int DW    = 8;
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } ld_state_e;

endpackage

// File: rtl/cnn_frame_bank.sv
// rtl/cnn_frame_bank.sv - N x DW element storage with a single write port and flat readout
module cnn_frame_bank
  import cnn_pkg::*;
#(
  parameter int DW_P  = cnn_pkg::DW,
  parameter int N_P   = cnn_pkg::N,
  parameter int IDX_P = cnn_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_P-1:0]   widx,
  input  logic [DW_P-1:0]    wdata,
  output logic [0:N_P*DW_P-1] mem
);

  logic [DW_P-1:0] cells [N_P];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_P; i++) cells[i] <= '0;
    end else if (we) begin
      cells[widx] <= wdata;
    end
  end

  // Element k sits at mem[k*DW +: DW], so element 0 occupies the leftmost bits.
  for (genvar g = 0; g < N_P; g++) begin : g_flat
    assign mem[g*DW_P +: DW_P] = cells[g];
  end

endmodule

// File: rtl/cnn_frame_loader.sv
// rtl/cnn_frame_loader.sv - byte-stream frame assembler and enable sequencer for the CNN core
module cnn_frame_loader
  import cnn_pkg::*;
#(
  parameter int ROWS_P = cnn_pkg::ROWS,
  parameter int COLS_P = cnn_pkg::COLS,
  parameter int DW_P   = cnn_pkg::DW
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DW_P-1:0]               s_data,
  input  logic                          s_last,
  input  logic                          cnn_done,
  output logic                          en,
  output logic [0:ROWS_P*COLS_P*DW_P-1] mem,
  output logic                          busy,
  output logic                          frame_err,
  output logic [15:0]                   frame_cnt
);

  localparam int NE = ROWS_P * COLS_P;
  localparam int IW = $clog2(NE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  ld_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          s_ready_d, en_d, busy_d, frame_err_d;
  logic [15:0]   frame_cnt_d;
  logic          accept, at_end;

  assign accept = s_valid && s_ready && (state_q == LOAD);
  assign at_end = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      s_ready   <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s_ready   <= s_ready_d;
      en        <= en_d;
      busy      <= busy_d;
      frame_err <= frame_err_d;
      frame_cnt <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          // Any frame boundary (good, short or overlong) restarts at element 0.
          if (at_end || s_last) idx_d = '0;
          else                  idx_d = idx_q + 1'b1;
          if (at_end && s_last) state_d = RUN;
        end
      end
      RUN: begin
        if (cnn_done && en) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    s_ready_d   = (state_d == LOAD);
    en_d        = (state_d == RUN);
    busy_d      = (state_d == RUN);
    frame_err_d = accept && (at_end ^ s_last);
    frame_cnt_d = frame_cnt;
    if (state_q == RUN && state_d == LOAD) frame_cnt_d = frame_cnt + 16'd1;
  end

  cnn_frame_bank #(
    .DW_P  (DW_P),
    .N_P   (NE),
    .IDX_P (IW)
  ) u_bank (
    .clk   (clk),
    .rst   (rst_b),
    .we    (accept),
    .widx  (idx_q),
    .wdata (s_data),
    .mem   (mem)
  );

endmodule

// File: tb/tb_cnn_frame_loader.sv
// tb/tb_cnn_frame_loader.sv - scoreboard bench for cnn_frame_loader
module tb_cnn_frame_loader;

  localparam int ROWS = 30;
  localparam int COLS = 10;
  localparam int DW   = 8;
  localparam int N    = ROWS * COLS;

  typedef logic [0:N*DW-1] frame_t;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          cnn_done = 1'b0;
  logic          en;
  frame_t        mem;
  logic          busy;
  logic          frame_err;
  logic [15:0]   frame_cnt;

  int     checks = 0;
  int     errors = 0;
  int     err_pulses = 0;
  int     exp_cnt = 0;
  logic   en_prev = 1'b0;
  frame_t sb_q[$];
  frame_t last_exp = '0;

  cnn_frame_loader dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .cnn_done  (cnn_done),
    .en        (en),
    .mem       (mem),
    .busy      (busy),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bad_bytes(input frame_t a, input frame_t b);
    int n = 0;
    for (int k = 0; k < N; k++) if (a[k*DW +: DW] !== b[k*DW +: DW]) n++;
    return n;
  endfunction

  // Output side of the scoreboard: each rising en must present the oldest queued frame.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
    if (en === 1'b1 && en_prev !== 1'b1) begin
      chk("sb_pending", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        last_exp = sb_q.pop_front();
        chk("mem_frame_bad_bytes", bad_bytes(mem, last_exp), 0);
      end
    end
    if (en === 1'b1) chk("s_ready_in_run", s_ready, 0);
    chk("busy_tracks_en", busy, en);
    en_prev = en;
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps);
    int   guard;
    logic acc;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    acc     = 1'b0;
    guard   = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  // mode 0: k mod 256, mode 1: 0x5A, mode 2: random
  task automatic send_frame(input int nbytes, input int last_at, input int mode,
                            input bit gaps, input bit good);
    frame_t        e = '0;
    logic [7:0]    d;
    for (int k = 0; k < nbytes; k++) begin
      if (mode == 0)      d = 8'(k);
      else if (mode == 1) d = 8'h5A;
      else                d = 8'($urandom);
      e[k*DW +: DW] = d;
      if (good && k == nbytes - 1) sb_q.push_back(e);
      send_byte(d, k == last_at, gaps);
      if (good && k == nbytes - 2) chk("en_before_last", en, 0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (good) chk("en_after_last", en, 1);
  endtask

  task automatic finish_run();
    chk("en_before_done", en, 1);
    cnn_done = 1'b1;
    @(posedge clk); #1;
    cnn_done = 1'b0;
    exp_cnt++;
    chk("en_after_done", en, 0);
    chk("busy_after_done", busy, 0);
    chk("frame_cnt", frame_cnt, 16'(exp_cnt));
    chk("s_ready_after_done", s_ready, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_b   = 1'b1;
    #1;
    exp_cnt = 0;
    chk("rst_en", en, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_mem_nonzero_bytes", bad_bytes(mem, '0), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    chk("s_ready_at_release", s_ready, 0);
    @(posedge clk); #1;
    chk("s_ready_after_release", s_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Ramp frame, then hold it through RUN while the stream keeps pushing 0xFF.
    send_frame(N, N - 1, 0, 1'b0, 1'b1);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    repeat (20) begin @(posedge clk); #1; end
    chk("s_ready_hold_run", s_ready, 0);
    chk("mem_frozen_bad_bytes", bad_bytes(mem, last_exp), 0);
    s_valid = 1'b0;
    finish_run();

    // Short frame followed by a clean 0x5A frame.
    send_frame(150, 149, 2, 1'b0, 1'b0);
    chk("short_frame_err", frame_err, 1);
    chk("short_en", en, 0);
    @(posedge clk); #1;
    chk("short_err_one_cycle", frame_err, 0);
    send_frame(N, N - 1, 1, 1'b0, 1'b1);
    finish_run();

    // Overlong frame: 300 bytes without last, then a good frame back to back.
    send_frame(N, -1, 2, 1'b0, 1'b0);
    chk("long_frame_err", frame_err, 1);
    chk("long_en", en, 0);
    send_frame(N, N - 1, 0, 1'b0, 1'b1);
    finish_run();

    // Reset mid-LOAD, reload, reset mid-RUN, reload.
    send_frame(100, -1, 2, 1'b0, 1'b0);
    do_reset();
    send_frame(N, N - 1, 1, 1'b0, 1'b1);
    do_reset();
    send_frame(N, N - 1, 2, 1'b0, 1'b1);
    finish_run();

    // cnn_done while loading is ignored; then a gappy random frame.
    cnn_done = 1'b1;
    @(posedge clk); #1;
    cnn_done = 1'b0;
    chk("done_in_load_cnt", frame_cnt, 16'(exp_cnt));
    chk("done_in_load_en", en, 0);
    chk("done_in_load_ready", s_ready, 1);
    send_frame(N, N - 1, 2, 1'b1, 1'b1);
    finish_run();

    repeat (3) @(posedge clk);
    #1;
    chk("frame_err_pulses", err_pulses, 2);
    chk("sb_leftover", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
